// File: rtl/speaker_div.sv
// Tone divider: 17-bit preloadable up-counter whose overflow toggles a square-wave speaker drive.
// Optional macro SPK_MUTE_REST_EN silences the output while the rest code (17'h1FFFF) is latched.
module speaker_div (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] cnt_start,
    output logic        spkout,
    output logic        tick,
    output logic [16:0] cur_start
);

    localparam logic [16:0] REST = 17'h1FFFF;

    logic [16:0] r_cnt;
    logic [16:0] r_cur_start;
    logic        r_spkout;
    logic        r_tick;
    logic        w_ovf;
    logic        w_spk_next;

    assign w_ovf = (r_cnt == REST);

`ifdef SPK_MUTE_REST_EN
    // Rest forces the drive low; leaving rest toggles from that low level.
    assign w_spk_next = (cnt_start == REST) ? 1'b0 : ~r_spkout;
`else
    assign w_spk_next = ~r_spkout;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= REST;
            r_cur_start <= REST;
            r_spkout    <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_tick <= w_ovf;
            if (w_ovf) begin
                // The preload is sampled only here, so a half-period is never cut short.
                r_cnt       <= cnt_start;
                r_cur_start <= cnt_start;
                r_spkout    <= w_spk_next;
            end else begin
                r_cnt <= r_cnt + 17'd1;
            end
        end
    end

    assign spkout    = r_spkout;
    assign tick      = r_tick;
    assign cur_start = r_cur_start;

endmodule
